// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C byte master: register map, command and
// status bit positions, FSM states and the per-phase bus level decode.
package i2c_master_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CMD  = 2'd1;

    localparam int CMD_START = 0;
    localparam int CMD_WRITE = 1;
    localparam int CMD_READ  = 2;
    localparam int CMD_STOP  = 3;
    localparam int CMD_NACK  = 4;

    localparam int ST_BUSY    = 0;
    localparam int ST_ACK_ERR = 1;
    localparam int ST_DONE    = 2;

    localparam int PHASE_W = 2;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Returns {scl, sda_released} for a given state/phase.
    function automatic logic [1:0] bus_levels(
        input state_t st,
        input phase_t ph,
        input logic   rel
    );
        logic [1:0] lv;
        lv = 2'b11;
        unique case (st)
            START: begin
                unique case (ph)
                    2'd0:    lv = 2'b01;
                    2'd1:    lv = 2'b11;
                    2'd2:    lv = 2'b10;
                    default: lv = 2'b00;
                endcase
            end
            DATA: lv = {(ph == 2'd1) || (ph == 2'd2), rel};
            STOP: begin
                unique case (ph)
                    2'd0:    lv = 2'b00;
                    2'd1:    lv = 2'b10;
                    default: lv = 2'b11;
                endcase
            end
            default: lv = 2'b11;
        endcase
        return lv;
    endfunction

    // SDA release level for a bit slot (8..1 data, 0 acknowledge).
    function automatic logic slot_rel(
        input logic [3:0] s,
        input logic       rd,
        input logic       nk,
        input logic [7:0] tx
    );
        if (s == 4'd0)
            return rd ? nk : 1'b1;
        return rd ? 1'b1 : tx[3'(s - 4'd1)];
    endfunction

endpackage

// File: rtl/i2c_byte_master_if.sv
// Avalon-MM register port plus I2C pin bundle of the byte master.
interface i2c_byte_master_if;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       scl_out;
    logic       sda_oe;
    logic       sda_in;

    modport slave (
        input  address, chipselect, write_n, writedata, sda_in,
        output readdata, scl_out, sda_oe
    );

    modport master (
        output address, chipselect, write_n, writedata, sda_in,
        input  readdata, scl_out, sda_oe
    );
endinterface

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period tick: down-counter of CLK_DIV cycles, reloaded on clear.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam logic [9:0] RELOAD = 10'(CLK_DIV - 1);

    logic [9:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= RELOAD;
        else if (en)
            cnt <= (cnt == 10'd0) ? RELOAD : cnt - 10'd1;
    end

    assign tick = en & ~clear & (cnt == 10'd0);

endmodule

// File: rtl/i2c_byte_master.sv
// Avalon-MM I2C byte master: START / WRITE / READ / STOP sequencing with
// 4-phase bit timing and ACK status.
module i2c_byte_master
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input logic clk,
    input logic reset,
    i2c_byte_master_if.slave bus
);

    logic       wr_stb;
    logic       cmd_wr;
    logic       cmd_go;
    logic       cmd_nop;
    logic       tick;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] txdata;
    logic [7:0] rxdata;
    logic [7:0] rx_sh;
    state_t     state;
    phase_t     phase;
    logic [3:0] slot;
    logic       do_write;
    logic       do_read;
    logic       do_stop;
    logic       nack;
    logic       scl_q;
    logic       sda_oe_q;

    state_t     go_state;
    logic       go_rd;
    state_t     nxt_state;
    phase_t     nxt_phase;
    logic [3:0] nxt_slot;
    logic       fin;
    logic [1:0] lv_go;
    logic [1:0] lv_adv;

    assign wr_stb  = bus.chipselect & ~bus.write_n;
    assign cmd_wr  = wr_stb && (bus.address == ADDR_CMD) && !busy;
    assign cmd_go  = cmd_wr && (bus.writedata[3:0] != 4'd0);
    assign cmd_nop = cmd_wr && (bus.writedata[3:0] == 4'd0);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .clear (cmd_go),
        .tick  (tick)
    );

    assign go_rd = bus.writedata[CMD_READ] & ~bus.writedata[CMD_WRITE];

    always_comb begin
        go_state = STOP;
        if (bus.writedata[CMD_START])
            go_state = START;
        else if (bus.writedata[CMD_WRITE] | bus.writedata[CMD_READ])
            go_state = DATA;
    end

    // Next position after the current phase expires.
    always_comb begin
        nxt_state = state;
        nxt_phase = phase + 2'd1;
        nxt_slot  = slot;
        fin       = 1'b0;
        if (phase == 2'd3) begin
            unique case (state)
                START: begin
                    nxt_slot = 4'd8;
                    if (do_write | do_read)
                        nxt_state = DATA;
                    else if (do_stop)
                        nxt_state = STOP;
                    else
                        fin = 1'b1;
                end
                DATA: begin
                    if (slot != 4'd0)
                        nxt_slot = slot - 4'd1;
                    else if (do_stop)
                        nxt_state = STOP;
                    else
                        fin = 1'b1;
                end
                default: fin = 1'b1;
            endcase
        end
    end

    assign lv_go = bus_levels(go_state, 2'd0,
        slot_rel(4'd8, go_rd, bus.writedata[CMD_NACK], txdata));
    assign lv_adv = bus_levels(nxt_state, nxt_phase,
        slot_rel(nxt_slot, do_read, nack, txdata));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txdata   <= '0;
            rxdata   <= '0;
            rx_sh    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            state    <= IDLE;
            phase    <= '0;
            slot     <= '0;
            do_write <= 1'b0;
            do_read  <= 1'b0;
            do_stop  <= 1'b0;
            nack     <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            if (wr_stb && (bus.address == ADDR_DATA) && !busy)
                txdata <= bus.writedata;
            if (cmd_nop) begin
                done    <= 1'b1;
                ack_err <= 1'b0;
            end else if (cmd_go) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                ack_err  <= 1'b0;
                do_write <= bus.writedata[CMD_WRITE];
                do_read  <= go_rd;
                do_stop  <= bus.writedata[CMD_STOP];
                nack     <= bus.writedata[CMD_NACK];
                state    <= go_state;
                phase    <= '0;
                slot     <= 4'd8;
                scl_q    <= lv_go[1];
                sda_oe_q <= ~lv_go[0];
            end else if (busy && tick) begin
                // sda_in is taken on the last clk of the SCL-high q2 phase
                if (state == DATA && phase == 2'd2) begin
                    if (slot == 4'd0) begin
                        if (do_write)
                            ack_err <= bus.sda_in;
                    end else if (do_read) begin
                        rx_sh <= {rx_sh[6:0], bus.sda_in};
                    end
                end
                if (state == DATA && phase == 2'd3 && slot == 4'd0
                    && do_read)
                    rxdata <= rx_sh;
                if (fin) begin
                    state <= IDLE;
                    phase <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state    <= nxt_state;
                    phase    <= nxt_phase;
                    slot     <= nxt_slot;
                    scl_q    <= lv_adv[1];
                    sda_oe_q <= ~lv_adv[0];
                end
            end
        end
    end

    assign bus.scl_out = scl_q;
    assign bus.sda_oe  = sda_oe_q;

    always_comb begin
        bus.readdata = '0;
        unique case (1'b1)
            (bus.address == ADDR_DATA): bus.readdata = rxdata;
            (bus.address == ADDR_CMD):
                bus.readdata = {5'd0, done, ack_err, busy};
            default: bus.readdata = '0;
        endcase
    end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Avalon-MM slave that runs I2C byte transfers in hardware, so the Nios II no longer bit-bangs SCL/SDA through single-bit PIOs. Software loads a byte and a command (START / WRITE / READ / STOP); the block sequences SCL and open-drain SDA with 4-phase bit timing and reports ACK status. It sits between the system interconnect and the board-level I2C pins that feed the audio codec and video decoder.

## Interface
- CLK_DIV, 125, clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz); legal range 2..1023
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  register select: 0 = TXDATA (write) / RXDATA (read); 1 = CMD (write) / STATUS (read); 2, 3 reserved, read 0
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  8  write data
- readdata  out  8  combinational read mux, zero wait states
- scl_out  out  1  SCL level; 1 = released/high
- sda_oe  out  1  1 = pull SDA low; 0 = released
- sda_in  in  1  SDA pin level, already synchronised at board level

## Operation
- Write strobe = chipselect & ~write_n. TXDATA write is ignored while busy.
- CMD bits: 0 START, 1 WRITE, 2 READ, 3 STOP, 4 NACK (send NACK after READ). Execution order is START, then WRITE or READ, then STOP. If WRITE and READ are both set, WRITE runs and READ is ignored. A CMD write while busy is ignored.
- CMD write with bits 0..3 all clear: no-op. Sets done and clears ack_err in the same cycle; busy stays 0.
- STATUS: bit0 busy, bit1 ack_err, bit2 done, bits 7:3 = 0. An accepted CMD write clears done and ack_err.
- States: IDLE, START, DATA (9 bit slots, index 8..0), STOP. Each state advances one phase q0..q3 per quarter tick.
- START phases (SCL/SDA-released): q0 0/1, q1 1/1, q2 1/0, q3 0/0. The same sequence serves as a repeated start.
- DATA bit slot phases:
  - q0: SCL=0, SDA driven to the bit value.
  - q1 and q2: SCL=1.
  - q3: SCL=0.
  - sda_in is sampled on the last clk of q2.
- WRITE byte: slots 8..1 send TXDATA MSB first; SDA is released in slot 0. The slot-0 sample is stored in ack_err (1 = NACK).
- READ byte: SDA is released in slots 8..1 and samples shift into RXDATA MSB first. Slot 0 drives ACK (SDA low), or releases SDA if NACK=1. RXDATA updates when the byte completes.
- STOP phases: q0 0/0, q1 1/0, q2 1/1, q3 1/1. Ends in IDLE with the bus released.
- Reset values: scl_out 1, sda_oe 0, TXDATA 0, RXDATA 0, STATUS 0, state IDLE, tick counter 0.
- Reset asserted mid-transfer releases both lines immediately. There is no STOP generation; software must recover the bus.
- No clock stretching: scl_out is never read back. No arbitration.

## Timing
- CMD accepted on edge T: busy = 1 and the first phase starts at T+1.
- Each phase lasts exactly CLK_DIV clk cycles.
- Durations: START 4*CLK_DIV, byte 36*CLK_DIV, STOP 4*CLK_DIV. Phases run back to back with no gap cycles.
- busy falls and done rises on the same edge that ends the final phase.
- RXDATA and ack_err are valid when busy falls.
- readdata follows address combinationally.

## Structure
- Shared package i2c_master_pkg holds:
  - register addresses ADDR_DATA = 0, ADDR_CMD = 1
  - CMD bit positions
  - STATUS bit positions
  - state enum IDLE/START/DATA/STOP
  - phase width (2 bits)
- Sub-module i2c_quarter_tick: a CLK_DIV down-counter with a clear input. It pulses tick for one cycle every CLK_DIV cycles while enabled and reloads on clear.
- Top level contains the register file, the FSM, the shift registers and the output decode. scl_out and sda_oe are registered.

## Test plan
- Reset with CLK_DIV=4: scl_out=1, sda_oe=0, STATUS reads 0x00, RXDATA reads 0x00.
- TXDATA=0xA5, CMD=0x0B (START+WRITE+STOP), bus model ACKs: SDA bit sequence 1,0,1,0,0,1,0,1, slot 0 released. busy lasts 176 cycles. STATUS ends at 0x04.
- Same transfer with slot 0 left high (NACK): STATUS=0x06.
- CMD=0x04 (READ), bus model returns 0x3C: RXDATA=0x3C, SDA held low through slot 0. CMD=0x14 instead: SDA released in slot 0.
- CMD write and TXDATA write during busy: ignored; the transfer completes with the original data and command.
- Reset pulse mid-byte: scl_out=1 and sda_oe=0 in the same cycle, STATUS=0x00. A following CMD=0x01 runs a clean START.
